rv32i_dmem: RTL

Parametrised 32-bit RV32I data memory with byte lanes, load/store sizing, sign/zero extension, and misalignment handling. It sits between the core's load/store unit and on-chip storage and replaces the byte-wide 2 KB data RAM. A valid/ready request handshake, a one-cycle response strobe, and a configurable wait-state counter let it model slower memories.

---
 rtl/rv32i_dmem.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/rv32i_dmem.sv
// RV32I data memory: four byte banks, sized loads/stores with sign/zero extension,
// valid/ready request, one-cycle response strobe, WAIT_STATES access delay.
// Optional RV32I_DMEM_MISALIGN_EN: flag misaligned accesses instead of masking address bits.
module rv32i_dmem #(
  parameter int unsigned AWIDTH      = 11,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IW    = AWIDTH - 2;
  localparam int unsigned DEPTH = 2 ** IW;
  localparam int unsigned CW    = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic [CW-1:0]     cnt_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [AWIDTH-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [7:0]        mem [4][DEPTH];

  logic [IW-1:0]     idx_c;
  logic              is_byte_c;
  logic              is_half_c;
  logic [1:0]        lane_c;
  logic [3:0]        be_c;
  logic [31:0]       wlane_c;
  logic [31:0]       merged_c;
  logic [31:0]       shifted_c;
  logic [31:0]       ldata_c;
  logic [31:0]       rdata_c;
  logic              err_c;
  logic              wr_en_c;
  logic              access_c;

  assign req_ready = (state == IDLE) && reset_n;
  assign access_c  = (state == ACCESS) && (cnt_q == '0);
  assign idx_c     = addr_q[AWIDTH-1:2];

  // Lane decode, write-first merge and load formatting of the latched request
  always_comb begin
    is_byte_c = (size_q == 2'b00);
    is_half_c = (size_q == 2'b01);
    lane_c    = 2'b00;
    be_c      = 4'hF;
    wlane_c   = wdata_q;
    merged_c  = '0;
    if (is_byte_c) begin
      lane_c  = addr_q[1:0];
      be_c    = 4'(4'b0001 << lane_c);
      wlane_c = {4{wdata_q[7:0]}};
    end else if (is_half_c) begin
      lane_c  = {addr_q[1], 1'b0};
      be_c    = 4'(4'b0011 << lane_c);
      wlane_c = {2{wdata_q[15:0]}};
    end
    for (int i = 0; i < 4; i++) begin
      merged_c[8*i +: 8] = (we_q && be_c[i]) ? wlane_c[8*i +: 8] : mem[i][idx_c];
    end
    shifted_c = merged_c >> {lane_c, 3'b000};
    if (is_byte_c)
      ldata_c = {{24{~uns_q & shifted_c[7]}}, shifted_c[7:0]};
    else if (is_half_c)
      ldata_c = {{16{~uns_q & shifted_c[15]}}, shifted_c[15:0]};
    else
      ldata_c = merged_c;
`ifdef RV32I_DMEM_MISALIGN_EN
    err_c   = (is_half_c && addr_q[0]) ||
              (!is_byte_c && !is_half_c && (addr_q[1:0] != 2'b00));
    wr_en_c = we_q && !err_c;
    rdata_c = err_c ? 32'h0 : ldata_c;
`else
    err_c   = 1'b0;
    wr_en_c = we_q;
    rdata_c = ldata_c;
`endif
  end

  // Byte banks are never reset
  always_ff @(posedge clock) begin
    if (access_c && wr_en_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem[i][idx_c] <= wlane_c[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= CW'(WAIT_STATES);
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata_c;
            rsp_err   <= err_c;
            state     <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
